// File: rtl/four_bank_mem_if.sv
// Request/response bundle between the cache controller (master) and the banked memory (slave).
interface four_bank_mem_if;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        data_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    modport master (
        output addr, data_in, wr, rd,
        input  data_out, data_valid, stall, busy, err
    );

    modport slave (
        input  addr, data_in, wr, rd,
        output data_out, data_valid, stall, busy, err
    );
endinterface

// File: rtl/four_bank_mem.sv
// Four-way word-interleaved main memory: per-bank busy counters and a fixed
// two-cycle read return pipeline.
module four_bank_mem #(
    parameter int unsigned MEM_WORDS_LOG2 = 15,
    parameter int unsigned BANK_BUSY      = 4
) (
    input  logic            clk,
    input  logic            rst,
    four_bank_mem_if.slave  bus
);
    localparam int unsigned NBANKS    = 4;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned MEM_DEPTH = 32'(1) << MEM_WORDS_LOG2;

    logic [NBANKS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NBANKS-1:0]            busy_q, busy_d;
    logic                         s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]            s1_data_q, s1_data_d;
    logic                         valid_q, valid_d;
    logic [DATA_W-1:0]            data_q, data_d;
    logic                         err_q, err_d;

    logic [DATA_W-1:0]            mem_q [MEM_DEPTH];

    logic                         req_c, illegal_c, stall_c, accept_c;
    logic [1:0]                   bank_c;
    logic [MEM_WORDS_LOG2-1:0]    widx_c;

    // Request classification against the registered bank state
    always_comb begin
        req_c     = bus.rd | bus.wr;
        illegal_c = (bus.rd & bus.wr) | (req_c & bus.addr[0]);
        bank_c    = bus.addr[2:1];
        widx_c    = bus.addr[MEM_WORDS_LOG2:1];
        stall_c   = req_c & ~illegal_c & busy_q[bank_c];
        accept_c  = req_c & ~illegal_c & ~busy_q[bank_c];
    end

    always_comb begin
        cnt_d  = cnt_q;
        busy_d = '0;
        for (int b = 0; b < int'(NBANKS); b++) begin
            if (accept_c && bank_c == 2'(b)) begin
                cnt_d[b] = CNT_W'(BANK_BUSY - 1);
            end else if (cnt_q[b] != '0) begin
                cnt_d[b] = cnt_q[b] - CNT_W'(1);
            end
            busy_d[b] = (cnt_d[b] != '0);
        end
        // Array word is captured at the accept edge, so later writes cannot disturb it
        s1_valid_d = accept_c & bus.rd;
        s1_data_d  = (accept_c & bus.rd) ? mem_q[widx_c] : '0;
        valid_d    = s1_valid_q;
        data_d     = s1_valid_q ? s1_data_q : '0;
        err_d      = err_q | illegal_c;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= '0;
            busy_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            err_q      <= err_d;
        end
    end

    // Array contents survive reset
    always_ff @(posedge clk) begin
        if (rst && accept_c && bus.wr) begin
            mem_q[widx_c] <= bus.data_in;
        end
    end

    assign bus.stall      = stall_c;
    assign bus.busy       = busy_q;
    assign bus.data_out   = data_q;
    assign bus.data_valid = valid_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_four_bank_mem.sv
// Directed bench for four_bank_mem with a cycle-level reference model and per-cycle compare.
module tb_four_bank_mem;
    localparam int BB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    four_bank_mem_if bus();

    four_bank_mem #(.MEM_WORDS_LOG2(15), .BANK_BUSY(BB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    typedef struct {
        int          due;
        logic [15:0] data;
    } resp_t;

    logic [15:0] mem_m [int];
    int          free_at [4];
    resp_t       rq [$];
    bit          err_m;

    logic        h_valid [0:1023];
    logic [15:0] h_data  [0:1023];
    logic        h_stall [0:1023];
    logic [3:0]  h_busy  [0:1023];
    logic        h_err   [0:1023];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endfunction

    // Reference model: a bank is free again BB cycles after an accept; reads return 2 cycles later
    bit m_req, m_ill;
    int m_b, m_w;
    always @(posedge clk) begin
        if (!rst) begin
            foreach (free_at[b]) free_at[b] = 0;
            rq.delete();
            err_m  = 1'b0;
            chk_en = 1'b1;
        end else begin
            m_req = bus.rd || bus.wr;
            m_ill = (bus.rd && bus.wr) || (m_req && bus.addr[0]);
            m_b   = int'(bus.addr[2:1]);
            m_w   = (int'(bus.addr) >> 1) & 32'h7FFF;
            if (m_ill) begin
                err_m = 1'b1;
            end else if (m_req && free_at[m_b] <= cyc) begin
                free_at[m_b] = cyc + BB;
                if (bus.wr) mem_m[m_w] = bus.data_in;
                else rq.push_back('{cyc + 2, mem_m.exists(m_w) ? mem_m[m_w] : 16'h0000});
            end
        end
        cyc++;
    end

    logic [3:0]  e_busy;
    logic        e_stall, e_valid, c_req, c_ill;
    logic [15:0] e_data;
    always @(negedge clk) begin
        if (chk_en) begin
            for (int b = 0; b < 4; b++) e_busy[b] = (free_at[b] > cyc);
            c_req   = bus.rd || bus.wr;
            c_ill   = (bus.rd && bus.wr) || (c_req && bus.addr[0]);
            e_stall = c_req && !c_ill && e_busy[bus.addr[2:1]];
            e_valid = 1'b0;
            e_data  = 16'h0000;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e_valid = 1'b1;
                e_data  = rq[0].data;
                void'(rq.pop_front());
            end
            chk("busy",       32'(bus.busy),       32'(e_busy));
            chk("stall",      32'(bus.stall),      32'(e_stall));
            chk("data_valid", 32'(bus.data_valid), 32'(e_valid));
            chk("data_out",   32'(bus.data_out),   32'(e_data));
            chk("err",        32'(bus.err),        32'(err_m));
            h_valid[cyc] = bus.data_valid;
            h_data[cyc]  = bus.data_out;
            h_stall[cyc] = bus.stall;
            h_busy[cyc]  = bus.busy;
            h_err[cyc]   = bus.err;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        repeat (n) step();
    endtask

    task automatic issue(bit r, bit w, logic [15:0] a, logic [15:0] d);
        bus.rd      = r;
        bus.wr      = w;
        bus.addr    = a;
        bus.data_in = d;
        step();
    endtask

    logic [15:0] line_a [4] = '{16'h0A10, 16'h0A12, 16'h0A14, 16'h0A16};
    logic [15:0] line_d [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    int w0, r0, n0, i0, j0, k0;

    initial begin
        bus.rd = 1'b1; bus.wr = 1'b0; bus.addr = 16'h0000; bus.data_in = 16'h0000;
        rst = 1'b0;
        step(); step();
        rst = 1'b1;
        idle(5);
        chk("idle_valid", 32'(h_valid[cyc-1]), 32'd0);
        chk("idle_busy",  32'(h_busy[cyc-1]),  32'd0);
        chk("idle_err",   32'(h_err[cyc-1]),   32'd0);

        // Line writeback then line fill
        w0 = cyc;
        for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, line_a[i], line_d[i]);
        r0 = cyc;
        for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, line_a[i], 16'h0000);
        idle(6);
        for (int i = 0; i < 4; i++) begin
            chk("line_wr_stall", 32'(h_stall[w0+i]),  32'd0);
            chk("line_rd_stall", 32'(h_stall[r0+i]),  32'd0);
            chk("line_valid",    32'(h_valid[r0+2+i]), 32'd1);
            chk("line_data",     32'(h_data[r0+2+i]),  32'(line_d[i]));
        end
        chk("line_after", 32'(h_valid[r0+6]), 32'd0);

        // Bank conflict on bank 0
        issue(1'b0, 1'b1, 16'h0028, 16'hBEEF);
        idle(4);
        n0 = cyc;
        issue(1'b0, 1'b1, 16'h0020, 16'hBEEF);
        repeat (4) issue(1'b1, 1'b0, 16'h0028, 16'h0000);
        idle(6);
        for (int i = 1; i <= 3; i++) chk("conflict_stall", 32'(h_stall[n0+i]), 32'd1);
        chk("conflict_accept", 32'(h_stall[n0+4]), 32'd0);
        chk("conflict_early",  32'(h_valid[n0+5]), 32'd0);
        chk("conflict_valid",  32'(h_valid[n0+6]), 32'd1);
        chk("conflict_data",   32'(h_data[n0+6]),  32'h0000BEEF);

        // Read/write ordering on one word
        issue(1'b0, 1'b1, 16'h0100, 16'h5555);
        idle(4);
        n0 = cyc;
        issue(1'b1, 1'b0, 16'h0100, 16'h0000);
        idle(3);
        issue(1'b0, 1'b1, 16'h0100, 16'h6666);
        idle(3);
        issue(1'b1, 1'b0, 16'h0100, 16'h0000);
        idle(4);
        chk("order_old_valid", 32'(h_valid[n0+2]),  32'd1);
        chk("order_old_data",  32'(h_data[n0+2]),   32'h00005555);
        chk("order_new_valid", 32'(h_valid[n0+10]), 32'd1);
        chk("order_new_data",  32'(h_data[n0+10]),  32'h00006666);

        // Illegal requests, including one aimed at a busy bank
        idle(4);
        i0 = cyc;
        issue(1'b1, 1'b1, 16'h0004, 16'hAAAA);
        j0 = cyc;
        issue(1'b1, 1'b0, 16'h0003, 16'h0000);
        k0 = cyc;
        issue(1'b0, 1'b1, 16'h0004, 16'h1234);
        issue(1'b1, 1'b1, 16'h0004, 16'h0000);
        idle(4);
        chk("ill_stall",     32'(h_stall[i0]),   32'd0);
        chk("ill_err_pre",   32'(h_err[i0]),     32'd0);
        chk("ill_err",       32'(h_err[i0+1]),   32'd1);
        chk("ill_busy",      32'(h_busy[i0+1]),  32'd0);
        chk("odd_stall",     32'(h_stall[j0]),   32'd0);
        chk("odd_err",       32'(h_err[j0+1]),   32'd1);
        chk("ill_busy_stall",32'(h_stall[k0+1]), 32'd0);
        chk("ill_busy_bank", 32'(h_busy[k0+1]),  32'b0100);
        chk("err_held",      32'(h_err[cyc-1]),  32'd1);

        // Reset while two reads are in flight
        n0 = cyc;
        issue(1'b1, 1'b0, 16'h0A10, 16'h0000);
        issue(1'b1, 1'b0, 16'h0A12, 16'h0000);
        bus.rd = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        idle(5);
        chk("rst_pre_valid", 32'(h_valid[n0+2]), 32'd1);
        chk("rst_pre_data",  32'(h_data[n0+2]),  32'h00001111);
        chk("rst_drop",      32'(h_valid[n0+3]), 32'd0);
        chk("rst_drop2",     32'(h_valid[n0+4]), 32'd0);
        chk("rst_busy",      32'(h_busy[n0+3]),  32'd0);
        chk("rst_err",       32'(h_err[n0+3]),   32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/four_bank_mem.md
Name: four_bank_mem

Overview:
- Banked main-memory model that sits directly downstream of the direct-mapped cache controller and services its line writeback and line fill bursts.
- Accepts one 16-bit word request per cycle, interleaved across four banks by address bits [2:1].
- Each bank stays busy for a fixed number of cycles after a request.
- Read data returns a fixed two cycles after acceptance, so the controller can issue four back-to-back word reads and capture data two cycles later.

Parameters:
- MEM_WORDS_LOG2, 15, log2 of the total word count; the word index is addr[MEM_WORDS_LOG2:1].
- BANK_BUSY, 4, cycles a bank is occupied per accepted request, counting the accept cycle. Legal range is 2..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low. Sampled on the clk rising edge; 0 = reset.
- addr  in  16  byte address of the request; bank = addr[2:1].
- data_in  in  16  write data.
- wr  in  1  write request.
- rd  in  1  read request.
- data_out  out  16  read data; valid only while data_valid=1, otherwise 0.
- data_valid  out  1  data_out holds returned read data this cycle.
- stall  out  1  current request is refused because its bank is busy (combinational).
- busy  out  4  per-bank busy flags, registered.
- err  out  1  sticky error flag.

Behaviour:
- Reset, on any edge with rst=0:
  - busy=0, all bank counters=0.
  - Read pipeline cleared: data_valid=0, data_out=0.
  - err=0.
  - Memory array contents are not cleared.
  - In-flight reads are dropped; no data_valid pulse occurs for them after reset.
- Request classification in a cycle:
  - req = rd|wr.
  - illegal = (rd&wr) | (req & addr[0]).
  - stall = req & ~illegal & busy[addr[2:1]].
  - Accept = req & ~illegal & ~stall.
- Illegal request:
  - Not accepted; no bank state changes.
  - err is set on that edge and stays 1 until reset.
  - stall=0 for illegal requests.
- Bank counters:
  - On accept, the target bank counter loads BANK_BUSY-1.
  - Each non-zero counter decrements by 1 per cycle.
  - busy[b] = (counter[b] != 0).
  - With the default of 4, a request accepted in cycle N marks the bank busy in N+1..N+3; a new request to that bank is accepted in N+4 at the earliest.
  - Requests to different banks may be accepted in consecutive cycles.
- Write:
  - On the accept edge, mem[addr[MEM_WORDS_LOG2:1]] <= data_in.
  - No response is produced.
- Read:
  - On the accept edge, the array word is sampled into pipeline stage 1 with valid=1.
  - Stage 1 moves to stage 2 on the next edge.
  - Stage 2 drives data_out and data_valid.
  - A read accepted in cycle N presents data in cycle N+2 for exactly one cycle.
  - If nothing is accepted, the pipeline shifts in valid=0.
  - Up to two reads are in flight; four consecutive reads to banks 0..3 produce data_valid in four consecutive cycles.
- Ordering:
  - A read returns the array contents at its accept edge.
  - A later write to the same word does not alter a read already in flight.
  - A read accepted after a write to the same word returns the written value.
- Address wrap: address bits above MEM_WORDS_LOG2 are ignored, so aliasing is permitted.
- No FSM beyond the per-bank counters and the 2-stage read pipeline.
- All outputs except stall are registered.

Test Plan:
- Reset and idle:
  - Stimulus: hold rst=0 for 2 cycles with rd=1, then release with rd=wr=0.
  - Required: busy=0000, data_valid=0, data_out=0000, err=0 throughout; no response appears after release.
- Line write then line read:
  - Stimulus: write 0x1111, 0x2222, 0x3333, 0x4444 to 0x0A10, 0x0A12, 0x0A14, 0x0A16 in consecutive cycles; then read the same four addresses in consecutive cycles starting at cycle R.
  - Required: no stall on any request; data_valid=1 in cycles R+2..R+5 with data_out 1111, 2222, 3333, 4444.
- Bank conflict:
  - Stimulus: write 0xBEEF to 0x0020 in cycle N; hold a read of 0x0028 (same bank 0) from cycle N+1.
  - Required: stall=1 in N+1..N+3, stall=0 and accept in N+4; data_out=BEEF with data_valid in N+6.
- Illegal requests:
  - Stimulus: rd=wr=1 at address 0x0004.
  - Required: no accept, busy unchanged, err=1 from the next cycle and held until reset.
  - Stimulus: rd=1 with addr=0x0003.
  - Required: err=1; stall=0.
- Read/write ordering:
  - Stimulus: read 0x0100 (holding 0x5555) in cycle N; write 0x6666 to 0x0100 in N+4; read 0x0100 in N+8.
  - Required: data_out=5555 at N+2; data_out=6666 at N+10.
- Reset mid-burst:
  - Stimulus: issue reads to banks 0 and 1 in cycles N and N+1; rst=0 in N+2.
  - Required: data_valid stays 0 in N+3 and after; busy=0000 in N+3.
